// File: rtl/change_negedge_delay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : change_negedge_delay_pkg
// Description : Shared defaults for the edge/change detector and delay line.
// Revision    : 1.0 - initial release
// ============================================================================
package change_negedge_delay_pkg;

   // Default word width of change_sig, data_in and data_out
   localparam int WIDTH_DEF = 32;

   // Default delay-line length in clock cycles
   localparam int DEPTH_DEF = 4;

   // Supported delay-line lengths
   localparam int DEPTH_MIN = 1;
   localparam int DEPTH_MAX = 64;

endpackage : change_negedge_delay_pkg
`default_nettype wire

// File: rtl/change_negedge_delay_sample_reg.sv
`default_nettype none
// ============================================================================
// Module      : sample_reg
// Description : Parameterised-width register, asynchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d on every rising edge; clear to zero whenever reset is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule : sample_reg
`default_nettype wire

// File: rtl/change_negedge_delay.sv
`default_nettype none
// ============================================================================
// Module      : change_negedge_delay
// Description : Falling-edge detector on sig, any-bit change detector on
//               change_sig, and a fixed DEPTH-cycle delay line on data_in.
//               The three paths share only clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module change_negedge_delay
   import change_negedge_delay_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF   // supported range DEPTH_MIN..DEPTH_MAX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig,
   output logic             neg_pulse,
   input  logic [WIDTH-1:0] change_sig,
   output logic             change_pulse,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   // Previous-cycle samples of the monitored inputs
   logic             sig_q;
   logic [WIDTH-1:0] change_q;

   // Delay-line taps: taps[0] is the live input, taps[k] is k cycles old
   logic [WIDTH-1:0] taps [0:DEPTH];

   // ------------------------------------------------------------------------
   // Falling-edge detector
   // ------------------------------------------------------------------------
   sample_reg #(
      .WIDTH (1)
   ) u_sig_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sig),
      .q     (sig_q)
   );

   // Pulse when the live level is low and the previous sample was high.
   // Because sig_q clears to 0, a low sig right after reset gives no pulse.
   assign neg_pulse = ~sig & sig_q;

   // ------------------------------------------------------------------------
   // Change detector
   // ------------------------------------------------------------------------
   sample_reg #(
      .WIDTH (WIDTH)
   ) u_change_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (change_sig),
      .q     (change_q)
   );

   // Any differing bit flags a change; a nonzero first word after reset
   // therefore flags against the cleared register.
   assign change_pulse = (change_sig != change_q);

   // ------------------------------------------------------------------------
   // Delay line: free-running shift register, one sample in and one out
   // per cycle, no stall. Output comes straight from the last register.
   // ------------------------------------------------------------------------
   assign taps[0] = data_in;

   for (genvar i = 0; i < DEPTH; i++) begin : g_delay
      sample_reg #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (taps[i]),
         .q     (taps[i+1])
      );
   end

   assign data_out = taps[DEPTH];

endmodule : change_negedge_delay
`default_nettype wire

// File: tb/tb_change_negedge_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_negedge_delay
// Description : Directed self-checking bench for change_negedge_delay.
//               Inputs change on the falling clock edge, outputs are
//               compared 1 ns later, registers load on the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_negedge_delay;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int NVEC  = 8;

   logic             clk;
   logic             rst_n;
   logic             sig;
   logic             neg_pulse;
   logic [WIDTH-1:0] change_sig;
   logic             change_pulse;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;

   int checks;
   int errors;

   change_negedge_delay #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sig          (sig),
      .neg_pulse    (neg_pulse),
      .change_sig   (change_sig),
      .change_pulse (change_pulse),
      .data_in      (data_in),
      .data_out     (data_out)
   );

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Directed vectors, one per cycle starting at the first post-reset cycle
   logic             v_sig   [NVEC] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic             v_neg   [NVEC] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [WIDTH-1:0] v_chg   [NVEC] = '{32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEE,
                                        32'hDEADBEEE, 32'h0, 32'h0, 32'h1};
   logic             v_chp   [NVEC] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [WIDTH-1:0] v_dout  [NVEC] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};

   // Reference model state for the random phase
   logic             m_sig;
   logic [WIDTH-1:0] m_chg;
   logic [WIDTH-1:0] hist [DEPTH];

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      sig        = 1'b0;
      change_sig = '0;
      data_in    = '0;

      // ---- Reset state: outputs evaluated against cleared registers ----
      @(negedge clk);
      #1;
      check("rst_data_out", data_out, 32'h0);
      check("rst_neg_pulse", {31'b0, neg_pulse}, 32'h0);
      check("rst_change_pulse", {31'b0, change_pulse}, 32'h0);
      sig        = 1'b1;
      change_sig = 32'h5;
      data_in    = 32'h77;
      #1;
      check("rst_change_nonzero", {31'b0, change_pulse}, 32'h1);
      check("rst_neg_sig_high", {31'b0, neg_pulse}, 32'h0);
      @(negedge clk);
      #1;
      check("rst_data_held", data_out, 32'h0);
      sig        = 1'b0;
      change_sig = '0;
      data_in    = '0;

      // ---- Directed: edges, changes and delay line together ----
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NVEC; k++) begin
         if (k != 0) @(negedge clk);
         sig        = v_sig[k];
         change_sig = v_chg[k];
         data_in    = WIDTH'(k + 1);
         #1;
         check($sformatf("neg_pulse[%0d]", k), {31'b0, neg_pulse}, {31'b0, v_neg[k]});
         check($sformatf("change_pulse[%0d]", k), {31'b0, change_pulse}, {31'b0, v_chp[k]});
         check($sformatf("data_out[%0d]", k), data_out, v_dout[k]);
      end

      // ---- Reset mid-stream: data_out=5, sig_q=1 ----
      @(negedge clk);
      #1;
      check("mid_data_out_before", data_out, 32'd5);
      check("mid_neg_sig_high", {31'b0, neg_pulse}, 32'h0);
      rst_n = 1'b0;
      #1;
      check("mid_data_out_async_clear", data_out, 32'h0);
      check("mid_change_vs_cleared", {31'b0, change_pulse}, 32'h1);
      @(negedge clk);
      rst_n   = 1'b1;
      sig     = 1'b0;
      data_in = '0;
      #1;
      check("post_rst_first_sig0", {31'b0, neg_pulse}, 32'h0);
      check("post_rst_data_out", data_out, 32'h0);

      // ---- Random regression against a previous-cycle model ----
      m_sig = sig;
      m_chg = change_sig;
      for (int i = 0; i < DEPTH; i++) hist[i] = '0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         sig = 1'($urandom);
         if ($urandom_range(3) != 0) change_sig = $urandom;
         data_in = $urandom;
         #1;
         check($sformatf("rnd_neg[%0d]", n), {31'b0, neg_pulse}, {31'b0, ~sig & m_sig});
         check($sformatf("rnd_chg[%0d]", n), {31'b0, change_pulse},
               {31'b0, (change_sig != m_chg)});
         check($sformatf("rnd_dout[%0d]", n), data_out, hist[DEPTH-1]);
         m_sig = sig;
         m_chg = change_sig;
         for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = data_in;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_change_negedge_delay
`default_nettype wire
